// File: rtl/control_unit_pipe.sv
// Pipelined instruction-class decoder with a registered control output stage.
// Block transfers are sequenced over multiple micro-ops when CU_BLOCK_XFER_EN is defined.
module control_unit_pipe #(
    parameter int NREG = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               mode,
    input  logic [3:0]               op_code,
    input  logic                     s_in,
    input  logic [NREG-1:0]          reg_list,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [3:0]               exe_cmd,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic                     wb_en,
    output logic                     s_out,
    output logic                     b_out,
    output logic [$clog2(NREG)-1:0]  xfer_idx,
    output logic                     xfer_last
);
    localparam int IW = $clog2(NREG);

    typedef enum logic {IDLE, XFER} state_t;

    typedef struct packed {
        logic          valid;
        logic [3:0]    cmd;
        logic          mem_read;
        logic          mem_write;
        logic          wb_en;
        logic          s;
        logic          b;
        logic [IW-1:0] idx;
        logic          last;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d, dec;
    logic   accept;

    assign in_ready = (state_q == IDLE) && !stall;
    assign accept   = in_valid && in_ready && !flush;

    // Single-op decode of the incoming request
    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        unique case (mode)
            2'b00: begin
                dec.wb_en = 1'b1;
                dec.s     = s_in;
                case (op_code)
                    4'b1101: dec.cmd = 4'b0001;
                    4'b1111: dec.cmd = 4'b1001;
                    4'b0100: dec.cmd = 4'b0010;
                    4'b0101: dec.cmd = 4'b0011;
                    4'b0010: dec.cmd = 4'b0100;
                    4'b0110: dec.cmd = 4'b0101;
                    4'b0000: dec.cmd = 4'b0110;
                    4'b1100: dec.cmd = 4'b0111;
                    4'b0001: dec.cmd = 4'b1000;
                    4'b1010: begin
                        dec.cmd   = 4'b0100;
                        dec.wb_en = 1'b0;
                        dec.s     = 1'b1;
                    end
                    4'b1000: begin
                        dec.cmd   = 4'b0110;
                        dec.wb_en = 1'b0;
                        dec.s     = 1'b1;
                    end
                    default: begin
                        dec.wb_en = 1'b0;
                        dec.s     = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                dec.cmd       = 4'b0010;
                dec.mem_read  = s_in;
                dec.wb_en     = s_in;
                dec.mem_write = !s_in;
            end
            2'b10: begin
                dec.b = 1'b1;
                dec.s = s_in;
            end
            default: ;
        endcase
    end

`ifdef CU_BLOCK_XFER_EN
    logic [NREG-1:0] list_q, list_d, src, rest;
    logic            s_lat_q, s_lat_d, uop_s, found;
    logic [IW-1:0]   lsb_idx;
    ctrl_t           uop;

    // In IDLE the micro-op comes from the incoming list, in XFER from the latched remainder
    assign src   = (state_q == XFER) ? list_q : reg_list;
    assign uop_s = (state_q == XFER) ? s_lat_q : s_in;
    assign rest  = src & (src - 1'b1);

    always_comb begin
        lsb_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (!found && src[i]) begin
                lsb_idx = i[IW-1:0];
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        uop           = '0;
        uop.valid     = 1'b1;
        uop.cmd       = 4'b0010;
        uop.mem_read  = uop_s;
        uop.wb_en     = uop_s;
        uop.mem_write = !uop_s;
        uop.idx       = lsb_idx;
        uop.last      = (rest == '0);
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        state_d = state_q;
        list_d  = list_q;
        s_lat_d = s_lat_q;
        if (flush) begin
            ctrl_d  = '0;
            state_d = IDLE;
            list_d  = '0;
        end else if (!stall) begin
            ctrl_d = '0;
            if (state_q == XFER) begin
                ctrl_d = uop;
                list_d = rest;
                if (rest == '0) state_d = IDLE;
            end else if (accept) begin
                if (mode == 2'b11) begin
                    if (reg_list != '0) begin
                        ctrl_d  = uop;
                        list_d  = rest;
                        s_lat_d = s_in;
                        if (rest != '0) state_d = XFER;
                    end
                end else begin
                    ctrl_d = dec;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            list_q  <= '0;
            s_lat_q <= 1'b0;
        end else begin
            list_q  <= list_d;
            s_lat_q <= s_lat_d;
        end
    end
`else
    logic unused_list;
    assign unused_list = ^reg_list;

    always_comb begin
        ctrl_d  = ctrl_q;
        state_d = IDLE;
        if (flush) begin
            ctrl_d = '0;
        end else if (!stall) begin
            ctrl_d = accept ? dec : '0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_valid = ctrl_q.valid;
    assign exe_cmd   = ctrl_q.cmd;
    assign mem_read  = ctrl_q.mem_read;
    assign mem_write = ctrl_q.mem_write;
    assign wb_en     = ctrl_q.wb_en;
    assign s_out     = ctrl_q.s;
    assign b_out     = ctrl_q.b;
    assign xfer_idx  = ctrl_q.idx;
    assign xfer_last = ctrl_q.last;
endmodule

// File: tb/tb_control_unit_pipe.sv
// Directed self-checking bench for control_unit_pipe (NREG=16); block-transfer
// vectors run when CU_BLOCK_XFER_EN is defined, the NOP decode of mode 11 otherwise.
module tb_control_unit_pipe;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, s_in, stall, flush;
    logic [1:0]  mode;
    logic [3:0]  op_code, exe_cmd, xfer_idx;
    logic [15:0] reg_list;
    logic        out_valid, mem_read, mem_write, wb_en, s_out, b_out, xfer_last;
    int          checks = 0;
    int          errors = 0;

    control_unit_pipe #(.NREG(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .op_code(op_code), .s_in(s_in), .reg_list(reg_list),
        .stall(stall), .flush(flush), .out_valid(out_valid), .exe_cmd(exe_cmd),
        .mem_read(mem_read), .mem_write(mem_write), .wb_en(wb_en), .s_out(s_out),
        .b_out(b_out), .xfer_idx(xfer_idx), .xfer_last(xfer_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // {valid, cmd, mem_read, mem_write, wb_en, s, b, idx, last}
    function automatic logic [31:0] obs();
        return {17'd0, out_valid, exe_cmd, mem_read, mem_write, wb_en, s_out, b_out, xfer_idx, xfer_last};
    endfunction

    function automatic logic [31:0] ex(input logic v, input logic [3:0] cmd, input logic mr, input logic mw,
                                       input logic wb, input logic s, input logic b,
                                       input logic [3:0] idx, input logic last);
        return {17'd0, v, cmd, mr, mw, wb, s, b, idx, last};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] m, input logic [3:0] op, input logic s, input logic [15:0] lst);
        in_valid = 1'b1;
        mode     = m;
        op_code  = op;
        s_in     = s;
        reg_list = lst;
    endtask

    task automatic single(input string tag, input logic [1:0] m, input logic [3:0] op, input logic s,
                          input logic [31:0] want);
        req(m, op, s, 16'h0);
        step();
        in_valid = 1'b0;
        check(tag, obs(), want);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; mode = '0; op_code = '0; s_in = 1'b0;
        reg_list = '0; stall = 1'b0; flush = 1'b0;
        step();
        step();
        check("reset_out", obs(), 32'h0);
        check("reset_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        single("add_s1", 2'b00, 4'b0100, 1'b1, ex(1, 4'b0010, 0, 0, 1, 1, 0, 0, 0));
        step();
        check("bubble", obs(), 32'h0);
        single("mov_s0", 2'b00, 4'b1101, 1'b0, ex(1, 4'b0001, 0, 0, 1, 0, 0, 0, 0));
        single("mvn_s1", 2'b00, 4'b1111, 1'b1, ex(1, 4'b1001, 0, 0, 1, 1, 0, 0, 0));
        single("sbc_s1", 2'b00, 4'b0110, 1'b1, ex(1, 4'b0101, 0, 0, 1, 1, 0, 0, 0));
        single("eor_s0", 2'b00, 4'b0001, 1'b0, ex(1, 4'b1000, 0, 0, 1, 0, 0, 0, 0));
        single("cmp", 2'b00, 4'b1010, 1'b0, ex(1, 4'b0100, 0, 0, 0, 1, 0, 0, 0));
        single("tst", 2'b00, 4'b1000, 1'b0, ex(1, 4'b0110, 0, 0, 0, 1, 0, 0, 0));
        single("nop_op", 2'b00, 4'b0011, 1'b1, ex(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
        single("ldr", 2'b01, 4'b0000, 1'b1, ex(1, 4'b0010, 1, 0, 1, 0, 0, 0, 0));
        single("str", 2'b01, 4'b0000, 1'b0, ex(1, 4'b0010, 0, 1, 0, 0, 0, 0, 0));
        single("branch", 2'b10, 4'b0101, 1'b1, ex(1, 4'b0000, 0, 0, 0, 1, 1, 0, 0));

        // stall holds the output register and blocks acceptance
        single("pre_stall", 2'b00, 4'b0000, 1'b1, ex(1, 4'b0110, 0, 0, 1, 1, 0, 0, 0));
        stall = 1'b1;
        req(2'b01, 4'b0000, 1'b1, 16'h0);
        #1;
        check("stall_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("stall_hold", obs(), ex(1, 4'b0110, 0, 0, 1, 1, 0, 0, 0));
        // flush overrides stall and the pending request
        flush = 1'b1;
        step();
        check("flush_out", obs(), 32'h0);
        flush = 1'b0;
        stall = 1'b0;
        in_valid = 1'b0;
        step();
        check("flush_noacc", obs(), 32'h0);

`ifdef CU_BLOCK_XFER_EN
        req(2'b11, 4'b0000, 1'b1, 16'h0109);
        step();
        in_valid = 1'b0;
        check("ldm_0", obs(), ex(1, 4'b0010, 1, 0, 1, 0, 0, 4'd0, 0));
        check("ldm_rdy0", {31'd0, in_ready}, 32'd0);
        step();
        check("ldm_3", obs(), ex(1, 4'b0010, 1, 0, 1, 0, 0, 4'd3, 0));
        check("ldm_rdy1", {31'd0, in_ready}, 32'd0);
        step();
        check("ldm_8", obs(), ex(1, 4'b0010, 1, 0, 1, 0, 0, 4'd8, 1));
        check("ldm_rdy2", {31'd0, in_ready}, 32'd1);
        step();
        check("ldm_end", obs(), 32'h0);

        req(2'b11, 4'b0000, 1'b0, 16'h0006);
        step();
        in_valid = 1'b0;
        check("stm_1", obs(), ex(1, 4'b0010, 0, 1, 0, 0, 0, 4'd1, 0));
        stall = 1'b1;
        step();
        check("stm_hold", obs(), ex(1, 4'b0010, 0, 1, 0, 0, 0, 4'd1, 0));
        stall = 1'b0;
        step();
        check("stm_2", obs(), ex(1, 4'b0010, 0, 1, 0, 0, 0, 4'd2, 1));

        req(2'b11, 4'b0000, 1'b1, 16'hF000);
        step();
        in_valid = 1'b0;
        check("fl_12", obs(), ex(1, 4'b0010, 1, 0, 1, 0, 0, 4'd12, 0));
        step();
        check("fl_13", obs(), ex(1, 4'b0010, 1, 0, 1, 0, 0, 4'd13, 0));
        stall = 1'b1;
        flush = 1'b1;
        step();
        check("fl_out", obs(), 32'h0);
        stall = 1'b0;
        flush = 1'b0;
        #1;
        check("fl_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("fl_no14", obs(), 32'h0);

        req(2'b11, 4'b0000, 1'b1, 16'h0000);
        step();
        in_valid = 1'b0;
        check("ldm_empty", obs(), 32'h0);

        req(2'b11, 4'b0000, 1'b0, 16'h00FF);
        step();
        in_valid = 1'b0;
        step();
        check("rst_pre", obs(), ex(1, 4'b0010, 0, 1, 0, 0, 0, 4'd1, 0));
`else
        req(2'b11, 4'b0000, 1'b1, 16'h0003);
        step();
        in_valid = 1'b0;
        check("m11_nop", obs(), ex(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
        check("m11_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("m11_end", obs(), 32'h0);
        single("rst_pre", 2'b01, 4'b0000, 1'b1, ex(1, 4'b0010, 1, 0, 1, 0, 0, 0, 0));
`endif
        // asynchronous reset mid-operation, then recovery
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", obs(), 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        single("post_rst_b", 2'b10, 4'b0000, 1'b0, ex(1, 4'b0000, 0, 0, 0, 0, 1, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
